// File: rtl/muldiv_hilo_sequencer.sv
// muldiv_hilo_sequencer: owns the HI/LO pair for the EX stage. MUL/MULU run a
// DATA_WIDTH-step shift-add multiplier and DIV/DIVU run a DATA_WIDTH-step
// restoring divider, both on operand magnitudes. A final FIX cycle applies
// the sign correction and writes HI/LO. MTHI/MTLO write HI/LO directly.
// Optional feature macro: MULDIV_FAST_MUL_EN. When it is defined, MUL/MULU
// finish in one cycle through a combinational multiplier.
module muldiv_hilo_sequencer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] rs,
   input  logic [DATA_WIDTH-1:0] rt,
   input  logic                  flush,
   input  logic                  rd_req,
   output logic                  busy,
   output logic                  stall,
   output logic                  done,
   output logic                  div_by_zero,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   localparam logic [2:0] OP_MUL  = 3'b000;
   localparam logic [2:0] OP_MULU = 3'b001;
   localparam logic [2:0] OP_DIV  = 3'b010;
   localparam logic [2:0] OP_DIVU = 3'b011;
   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   // Magnitude of v when it is treated as a signed value, v itself otherwise.
   function automatic logic [W-1:0] mag_f(input logic [W-1:0] v, input logic sgn);
      return (sgn && v[W-1]) ? -v : v;
   endfunction

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2*W-1:0]  acc_q, acc_d;     // product, or {remainder, quotient}
   logic [W-1:0]    opb_q, opb_d;     // multiplicand or divisor magnitude
   logic [W-1:0]    rs_q, rs_d;       // raw dividend, returned in HI on divide by zero
   logic            is_div_q, is_div_d;
   logic            neg_lo_q, neg_lo_d; // negate product / quotient
   logic            neg_hi_q, neg_hi_d; // negate remainder
   logic            dz_q, dz_d;       // divisor was zero
   logic [W-1:0]    hi_q, hi_d;
   logic [W-1:0]    lo_q, lo_d;
   logic            done_q, done_d;
   logic            dbz_q, dbz_d;

   logic            sgn_s;
   logic [W:0]      mul_sum_s;
   logic [2*W-1:0]  mul_next_s;
   logic [W:0]      div_shift_s;
   logic [W:0]      div_diff_s;
   logic [2*W-1:0]  div_next_s;
   logic [2*W-1:0]  mul_res_s;
   logic [W-1:0]    quo_res_s;
   logic [W-1:0]    rem_res_s;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*W-1:0]  fast_a_s;
   logic [2*W-1:0]  fast_b_s;
   logic [2*W-1:0]  fast_prod_s;
`endif

   assign sgn_s = ~op[0];

   // One iteration step of both datapaths plus the sign-corrected results.
   always_comb begin
      mul_sum_s   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
      mul_next_s  = {mul_sum_s, acc_q[W-1:1]};
      div_shift_s = {acc_q[2*W-1:W], acc_q[W-1]};
      div_diff_s  = div_shift_s - {1'b0, opb_q};
      if (!div_diff_s[W]) begin
         div_next_s = {div_diff_s[W-1:0], acc_q[W-2:0], 1'b1};
      end else begin
         div_next_s = {div_shift_s[W-1:0], acc_q[W-2:0], 1'b0};
      end
      mul_res_s = neg_lo_q ? -acc_q : acc_q;
      quo_res_s = neg_lo_q ? -acc_q[W-1:0] : acc_q[W-1:0];
      rem_res_s = neg_hi_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
   end

`ifdef MULDIV_FAST_MUL_EN
   // Single-cycle product; sign extension to 2W makes the truncated product signed-correct.
   always_comb begin
      fast_a_s    = sgn_s ? {{W{rs[W-1]}}, rs} : {{W{1'b0}}, rs};
      fast_b_s    = sgn_s ? {{W{rt[W-1]}}, rt} : {{W{1'b0}}, rt};
      fast_prod_s = fast_a_s * fast_b_s;
   end
`endif

   // Next-state and datapath control for the IDLE / ITER / FIX sequencer.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      rs_d     = rs_q;
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dbz_d    = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               dbz_d = 1'b0;
               case (op)
                  OP_MTHI: hi_d = rs;
                  OP_MTLO: lo_d = rs;
                  OP_MUL, OP_MULU: begin
`ifdef MULDIV_FAST_MUL_EN
                     {hi_d, lo_d} = fast_prod_s;
                     done_d       = 1'b1;
`else
                     state_d  = S_ITER;
                     cnt_d    = CNT_INIT;
                     acc_d    = {{W{1'b0}}, mag_f(rt, sgn_s)};
                     opb_d    = mag_f(rs, sgn_s);
                     is_div_d = 1'b0;
                     neg_lo_d = sgn_s & (rs[W-1] ^ rt[W-1]);
                     neg_hi_d = 1'b0;
                     dz_d     = 1'b0;
`endif
                  end
                  OP_DIV, OP_DIVU: begin
                     state_d  = S_ITER;
                     cnt_d    = CNT_INIT;
                     acc_d    = {{W{1'b0}}, mag_f(rs, sgn_s)};
                     opb_d    = mag_f(rt, sgn_s);
                     rs_d     = rs;
                     is_div_d = 1'b1;
                     neg_lo_d = sgn_s & (rs[W-1] ^ rt[W-1]);
                     neg_hi_d = sgn_s & rs[W-1];
                     dz_d     = (rt == {W{1'b0}});
                  end
                  default: state_d = S_IDLE;
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ITER: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = is_div_q ? div_next_s : mul_next_s;
               if (cnt_q == CNT_ZERO) begin
                  state_d = S_FIX;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (flush) begin
               done_d = 1'b0;
            end else begin
               done_d = 1'b1;
               if (!is_div_q) begin
                  {hi_d, lo_d} = mul_res_s;
               end else if (dz_q) begin
                  hi_d  = rs_q;
                  lo_d  = {W{1'b1}};
                  dbz_d = 1'b1;
               end else begin
                  hi_d = rem_res_s;
                  lo_d = quo_res_s;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset clears HI/LO and drops any in-flight result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= CNT_ZERO;
         acc_q    <= {(2*W){1'b0}};
         opb_q    <= {W{1'b0}};
         rs_q     <= {W{1'b0}};
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= {W{1'b0}};
         lo_q     <= {W{1'b0}};
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         rs_q     <= rs_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign stall       = busy & (start | rd_req);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_sequencer.sv
// Self-checking bench for muldiv_hilo_sequencer: a table of MUL/DIV vectors
// checked through a scoreboard queue, plus hand-written corner sequences.
module tb_muldiv_hilo_sequencer;

   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = W + 2;
`endif
   localparam int DIV_LAT = W + 2;

   localparam logic [2:0] OP_MUL  = 3'b000;
   localparam logic [2:0] OP_MULU = 3'b001;
   localparam logic [2:0] OP_DIV  = 3'b010;
   localparam logic [2:0] OP_DIVU = 3'b011;
   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    op = 3'b000;
   logic [W-1:0]  rs = 32'h0;
   logic [W-1:0]  rt = 32'h0;
   logic          flush = 1'b0;
   logic          rd_req = 1'b0;
   logic          busy, stall, done, div_by_zero;
   logic [W-1:0]  hi, lo;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct packed {
      logic [2:0]   op;
      logic [W-1:0] rs;
      logic [W-1:0] rt;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } vec_t;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      logic         is_div;
      int           t0;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[14];

   muldiv_hilo_sequencer #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
      .flush(flush), .rd_req(rd_req), .busy(busy), .stall(stall), .done(done),
      .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic is_div);
      return is_div ? DIV_LAT : MUL_LAT;
   endfunction

   task automatic drive(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1;
      op    = o;
      rs    = a;
      rt    = b;
   endtask

   task automatic push_exp(input logic [W-1:0] h, input logic [W-1:0] l, input logic z,
                           input logic [2:0] o);
      exp_t e;
      e.hi     = h;
      e.lo     = l;
      e.dbz    = z;
      e.is_div = o[1];
      e.t0     = cyc;
      sb_q.push_back(e);
   endtask

   task automatic wait_idle;
      for (int k = 0; k < 100; k++) begin
         if (busy === 1'b0) break;
         step;
      end
   endtask

   // Waits (bounded) for done, then pops the scoreboard and checks result and latency.
   task automatic wait_done(input string name);
      exp_t e;
      bit   got = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
         step;
      end
      chk({name, "_done_seen"}, 64'(got), 64'd1);
      if (got) begin
         chk({name, "_sb_depth"}, 64'(sb_q.size()), 64'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({name, "_hi"}, 64'(hi), 64'(e.hi));
            chk({name, "_lo"}, 64'(lo), 64'(e.lo));
            chk({name, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
            chk({name, "_latency"}, 64'(cyc - e.t0), 64'(exp_lat(e.is_div)));
         end
         step;
         chk({name, "_done_pulse"}, 64'(done), 64'd0);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      string nm;
      nm = $sformatf("vec%0d", idx);
      wait_idle;
      drive(v.op, v.rs, v.rt);
      push_exp(v.hi, v.lo, v.dbz, v.op);
      step;
      start = 1'b0;
      chk({nm, "_dbz_cleared"}, 64'(div_by_zero), 64'd0);
      if (exp_lat(v.op[1]) > 1) chk({nm, "_busy"}, 64'(busy), 64'd1);
      wait_done(nm);
   endtask

   initial begin
      int  stall_bad;
      bit  saw_done;

      vecs[0]  = '{OP_MULU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
      vecs[1]  = '{OP_MUL,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[2]  = '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[3]  = '{OP_DIVU, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
      vecs[4]  = '{OP_DIVU, 32'h00000032, 32'h00000007, 32'h00000001, 32'h00000007, 1'b0};
      vecs[5]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[6]  = '{OP_MUL,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[7]  = '{OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[8]  = '{OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[9]  = '{OP_DIV,  32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};
      vecs[10] = '{OP_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
      vecs[11] = '{OP_MUL,  32'h00003039, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFCFC7, 1'b0};
      vecs[12] = '{OP_DIV,  32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0};
      vecs[13] = '{OP_DIV,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};

      // Reset state
      step;
      step;
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dbz", 64'(div_by_zero), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      rst_n = 1'b1;
      step;

      // MTLO / MTHI write directly without a done pulse
      drive(OP_MTLO, 32'h00001234, 32'h0);
      step;
      start = 1'b0;
      chk("mtlo_lo", 64'(lo), 64'h1234);
      chk("mtlo_done", 64'(done), 64'd0);
      chk("mtlo_busy", 64'(busy), 64'd0);
      drive(OP_MTHI, 32'h0000ABCD, 32'h0);
      step;
      start = 1'b0;
      chk("mthi_hi", 64'(hi), 64'hABCD);

      // Flush and start in the same idle cycle: nothing captured
      drive(OP_MTLO, 32'h00005555, 32'h0);
      flush = 1'b1;
      step;
      start = 1'b0;
      flush = 1'b0;
      chk("flush_start_lo", 64'(lo), 64'h1234);

      for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

      // Start while busy is ignored and stalls the requester
      wait_idle;
      drive(OP_DIV, 32'd100, 32'd7);
      push_exp(32'd2, 32'd14, 1'b0, OP_DIV);
      step;
      drive(OP_MTLO, 32'h0000DEAD, 32'h0);
      stall_bad = 0;
      for (int k = 0; k < 5; k++) begin
         if (stall !== 1'b1) stall_bad++;
         step;
      end
      start = 1'b0;
      chk("busy_start_stall", 64'(stall_bad), 64'd0);
      wait_done("busy_start");

      // Flush mid-divide: back to IDLE, HI/LO kept, no done
      wait_idle;
      drive(OP_DIV, 32'hFFFFFF9C, 32'd3);
      step;
      start = 1'b0;
      for (int k = 0; k < 9; k++) step;
      flush = 1'b1;
      step;
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_hi", 64'(hi), 64'd2);
      chk("flush_lo", 64'(lo), 64'd14);
      saw_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done === 1'b1) saw_done = 1'b1;
         step;
      end
      chk("flush_no_done", 64'(saw_done), 64'd0);

      // MFHI/MFLO during a divide: stall until the done cycle
      wait_idle;
      drive(OP_DIVU, 32'd50, 32'd7);
      rd_req = 1'b1;
      push_exp(32'd1, 32'd7, 1'b0, OP_DIVU);
      step;
      start = 1'b0;
      stall_bad = 0;
      for (int k = 0; k < 200; k++) begin
         if (done === 1'b1) break;
         if (stall !== 1'b1) stall_bad++;
         step;
      end
      chk("rdreq_stall_busy", 64'(stall_bad), 64'd0);
      chk("rdreq_stall_done", 64'(stall), 64'd0);
      wait_done("rdreq");
      rd_req = 1'b0;

      // Reset asserted mid-multiply
      wait_idle;
      drive(OP_MUL, 32'd7, 32'd9);
      step;
      start = 1'b0;
      for (int k = 0; k < 5; k++) step;
      rst_n = 1'b0;
      #1;
      chk("midrst_hi", 64'(hi), 64'd0);
      chk("midrst_lo", 64'(lo), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      step;
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done === 1'b1) saw_done = 1'b1;
         step;
      end
      chk("midrst_no_done", 64'(saw_done), 64'd0);
      chk("midrst_lo_after", 64'(lo), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
